// File: rtl/aesl_deadlock_watchdog.sv
// Deadlock watchdog: confirms a persistent block_in, snapshots flags, counts events.
// Optional transient-episode counter enabled by `define AESL_DEADLOCK_TRANSIENT_LOG_EN.
module aesl_deadlock_watchdog #(
    parameter int unsigned THRESHOLD = 16,
    parameter int unsigned CNT_W     = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       block_in,
    input  logic [1:0] axis_block_sigs,
    input  logic [4:0] inst_idle_sigs,
    input  logic       clear,
    output logic       deadlock,
    output logic       deadlock_pulse,
    output logic [1:0] snap_axis,
    output logic [4:0] snap_idle,
    output logic [7:0] event_cnt,
    output logic [7:0] transient_cnt
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SUSPECT   = 2'd1,
        CONFIRMED = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(THRESHOLD - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dl_q, dl_d;
    logic             pulse_q, pulse_d;
    logic [1:0]       axis_q, axis_d;
    logic [4:0]       idle_q, idle_d;
    logic [7:0]       ev_q, ev_d;
    logic             confirm;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        axis_d  = axis_q;
        idle_d  = idle_q;
        confirm = 1'b0;
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            axis_d  = '0;
            idle_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (block_in) begin
                        state_d = SUSPECT;
                        cnt_d   = CNT_W'(1);
                    end
                end
                SUSPECT: begin
                    if (!block_in) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == LAST) begin
                        state_d = CONFIRMED;
                        confirm = 1'b1;
                        pulse_d = 1'b1;
                        axis_d  = axis_block_sigs;
                        idle_d  = inst_idle_sigs;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                CONFIRMED: ;
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        dl_d = (state_d == CONFIRMED);
        ev_d = (confirm && ev_q != 8'hFF) ? ev_q + 8'd1 : ev_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dl_q    <= 1'b0;
            pulse_q <= 1'b0;
            axis_q  <= '0;
            idle_q  <= '0;
            ev_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dl_q    <= dl_d;
            pulse_q <= pulse_d;
            axis_q  <= axis_d;
            idle_q  <= idle_d;
            ev_q    <= ev_d;
        end
    end

    assign deadlock       = dl_q;
    assign deadlock_pulse = pulse_q;
    assign snap_axis      = axis_q;
    assign snap_idle      = idle_q;
    assign event_cnt      = ev_q;

`ifdef AESL_DEADLOCK_TRANSIENT_LOG_EN
    // Only a block_in drop aborts an episode; a clear never counts.
    logic       abort;
    logic [7:0] tr_q;

    assign abort = (state_q == SUSPECT) && !block_in && !clear;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tr_q <= '0;
        end else if (abort && tr_q != 8'hFF) begin
            tr_q <= tr_q + 8'd1;
        end
    end

    assign transient_cnt = tr_q;
`else
    assign transient_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_aesl_deadlock_watchdog.sv
// Scoreboard bench for aesl_deadlock_watchdog with THRESHOLD=4.
module tb_aesl_deadlock_watchdog;

`ifdef AESL_DEADLOCK_TRANSIENT_LOG_EN
    localparam logic [7:0] TR1 = 8'd1;
`else
    localparam logic [7:0] TR1 = 8'd0;
`endif

    bit         clock;
    logic       reset;
    logic       block_in;
    logic [1:0] axis_block_sigs;
    logic [4:0] inst_idle_sigs;
    logic       clear;
    logic       deadlock;
    logic       deadlock_pulse;
    logic [1:0] snap_axis;
    logic [4:0] snap_idle;
    logic [7:0] event_cnt;
    logic [7:0] transient_cnt;

    aesl_deadlock_watchdog #(.THRESHOLD(4), .CNT_W(16)) dut (
        .clock          (clock),
        .reset          (reset),
        .block_in       (block_in),
        .axis_block_sigs(axis_block_sigs),
        .inst_idle_sigs (inst_idle_sigs),
        .clear          (clear),
        .deadlock       (deadlock),
        .deadlock_pulse (deadlock_pulse),
        .snap_axis      (snap_axis),
        .snap_idle      (snap_idle),
        .event_cnt      (event_cnt),
        .transient_cnt  (transient_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         cyc;
        string      name;
        logic       dl;
        logic       pl;
        logic [1:0] ax;
        logic [4:0] id;
        logic [7:0] ev;
        logic [7:0] tr;
    } exp_t;

    exp_t sb[$];
    int   pq[$];
    int   cyc;
    int   tests;
    int   fails;
    bit   done;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_at(input int d, input string nm, input logic dl,
                             input logic pl, input logic [1:0] ax,
                             input logic [4:0] id, input logic [7:0] ev,
                             input logic [7:0] tr);
        exp_t e;
        int   k;
        e.cyc = cyc + d;
        e.name = nm;
        e.dl = dl;
        e.pl = pl;
        e.ax = ax;
        e.id = id;
        e.ev = ev;
        e.tr = tr;
        k = 0;
        while (k < sb.size() && sb[k].cyc <= e.cyc) k++;
        sb.insert(k, e);
    endtask

    // State monitor: compares all outputs on the cycles the stimulus booked.
    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            tests++;
            if (e.cyc < cyc) begin
                fails++;
                $display("FAIL %s: check for cycle %0d missed (now %0d)",
                         e.name, e.cyc, cyc);
            end else if (deadlock !== e.dl || deadlock_pulse !== e.pl ||
                         snap_axis !== e.ax || snap_idle !== e.id ||
                         event_cnt !== e.ev || transient_cnt !== e.tr) begin
                fails++;
                $display("FAIL %s @%0d: got dl=%b pl=%b ax=%b id=%b ev=%0d tr=%0d, want dl=%b pl=%b ax=%b id=%b ev=%0d tr=%0d",
                         e.name, cyc, deadlock, deadlock_pulse, snap_axis,
                         snap_idle, event_cnt, transient_cnt, e.dl, e.pl,
                         e.ax, e.id, e.ev, e.tr);
            end
        end
    end

    // Pulse monitor: every pulse must match a booked confirmation cycle.
    always @(negedge clock) begin
        if (!done) begin
            while (pq.size() > 0 && pq[0] < cyc) begin
                tests++;
                fails++;
                $display("FAIL pulse_missing: none at cycle %0d, want 1", pq[0]);
                void'(pq.pop_front());
            end
            if (deadlock_pulse === 1'b1) begin
                tests++;
                if (pq.size() > 0 && pq[0] == cyc) begin
                    void'(pq.pop_front());
                end else begin
                    fails++;
                    $display("FAIL pulse_spurious: got pulse at cycle %0d, want none", cyc);
                end
            end
        end
    end

    initial begin
        logic [7:0] ev_m;
        done = 0;
        tests = 0;
        fails = 0;
        reset = 0;
        block_in = 0;
        clear = 0;
        axis_block_sigs = 0;
        inst_idle_sigs = 0;
        tick();
        tick();
        expect_at(0, "reset_state", 0, 0, 0, 0, 0, 0);
        tick();
        reset = 1;
        tick();

        // Persistent block confirms after 4 cycles.
        block_in = 1;
        axis_block_sigs = 2'b10;
        inst_idle_sigs = 5'b00001;
        expect_at(3, "s1_pre", 0, 0, 0, 0, 0, 0);
        expect_at(4, "s1_conf", 1, 1, 2'b10, 5'b00001, 1, 0);
        expect_at(5, "s1_hold", 1, 0, 2'b10, 5'b00001, 1, 0);
        pq.push_back(cyc + 4);
        repeat (5) tick();

        // Block drops for 10 cycles: deadlock and snapshots stay sticky.
        block_in = 0;
        axis_block_sigs = 2'b01;
        inst_idle_sigs = 5'b11111;
        expect_at(10, "s3_sticky", 1, 0, 2'b10, 5'b00001, 1, 0);
        repeat (10) tick();
        clear = 1;
        expect_at(1, "s3_clear", 0, 0, 0, 0, 1, 0);
        tick();
        clear = 0;
        tick();

        // Three-cycle episode aborts.
        block_in = 1;
        expect_at(3, "s2_nodl", 0, 0, 0, 0, 1, 0);
        expect_at(4, "s2_abort", 0, 0, 0, 0, 1, TR1);
        repeat (3) tick();
        block_in = 0;
        tick();
        tick();

        // Clear coincides with the confirming condition.
        block_in = 1;
        expect_at(4, "s4_clear_win", 0, 0, 0, 0, 1, TR1);
        expect_at(5, "s4_idle", 0, 0, 0, 0, 1, TR1);
        repeat (3) tick();
        clear = 1;
        tick();
        clear = 0;
        block_in = 0;
        tick();
        tick();

        // Asynchronous reset mid-episode at count 2, then a clean episode.
        block_in = 1;
        axis_block_sigs = 2'b01;
        inst_idle_sigs = 5'b10110;
        tick();
        tick();
        reset = 0;
        expect_at(0, "s5_async_rst", 0, 0, 0, 0, 0, 0);
        tick();
        reset = 1;
        expect_at(3, "s5_pre", 0, 0, 0, 0, 0, 0);
        expect_at(4, "s5_conf", 1, 1, 2'b01, 5'b10110, 1, 0);
        pq.push_back(cyc + 4);
        repeat (5) tick();
        block_in = 0;
        clear = 1;
        tick();
        clear = 0;
        tick();

        // 256 confirm/clear rounds: event_cnt saturates at 255.
        ev_m = 8'd1;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] iv;
            iv = 8'(i);
            if (ev_m != 8'hFF) ev_m = ev_m + 8'd1;
            block_in = 1;
            axis_block_sigs = iv[1:0];
            inst_idle_sigs = iv[4:0];
            expect_at(4, "s6_conf", 1, 1, iv[1:0], iv[4:0], ev_m, 0);
            pq.push_back(cyc + 4);
            repeat (4) tick();
            block_in = 0;
            clear = 1;
            tick();
            clear = 0;
        end
        expect_at(1, "s6_saturated", 0, 0, 0, 0, 8'd255, 0);
        tick();
        tick();
        tick();

        done = 1;
        tests++;
        if (sb.size() != 0 || pq.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d checks and %0d pulses pending, want 0",
                     sb.size(), pq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
